// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT framing transmitter:
//   fsm_state_e         - framer state encoding (IDLE, CFG, STREAM, PAD)
//   FFT_POINTS_DEFAULT  - default samples per frame
//   ZERO_SAMPLE         - padding sample; sliced to the sample width by users
//   cnt_width()         - sample-counter width for a given frame length
// -----------------------------------------------------------------------------
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CFG    = 2'd1,
    ST_STREAM = 2'd2,
    ST_PAD    = 2'd3
  } fsm_state_e;

  localparam int FFT_POINTS_DEFAULT = 1024;

  // Wide enough for any supported sample ({imag, real}, up to 32+32 bits).
  localparam int                   MAX_SAMPLE_W = 64;
  localparam logic [MAX_SAMPLE_W-1:0] ZERO_SAMPLE = '0;

  // Frame lengths are powers of two, so the counter wraps naturally.
  function automatic int cnt_width(input int points);
    return $clog2(points);
  endfunction

endpackage

// File: rtl/axi4s_skid_buf.sv
// -----------------------------------------------------------------------------
// axi4s_skid_buf
// Two-entry AXI4-Stream skid buffer with a registered output stage and a
// tlast sideband. The head entry drives the master port; the tail entry
// absorbs one beat when the downstream stalls, so the upstream ready is a
// pure register output (not the downstream ready).
//
// Ports:
//   i_aclk, i_aresetn         clock, synchronous active-low reset
//   i_s_tvalid/o_s_tready     slave handshake
//   i_s_tdata/i_s_tlast       slave payload
//   o_m_tvalid/i_m_tready     master handshake
//   o_m_tdata/o_m_tlast       master payload
//   o_empty                   no beat held
// -----------------------------------------------------------------------------
module axi4s_skid_buf #(
  parameter int DATA_W = 32
) (
  input  logic              i_aclk,
  input  logic              i_aresetn,
  input  logic              i_s_tvalid,
  output logic              o_s_tready,
  input  logic [DATA_W-1:0] i_s_tdata,
  input  logic              i_s_tlast,
  output logic              o_m_tvalid,
  input  logic              i_m_tready,
  output logic [DATA_W-1:0] o_m_tdata,
  output logic              o_m_tlast,
  output logic              o_empty
);

  logic              head_vld_q, tail_vld_q;
  logic [DATA_W-1:0] head_data_q, tail_data_q;
  logic              head_last_q, tail_last_q;
  logic              push, pop;

  // Ready only depends on the tail slot, so a push never coincides with a
  // full buffer and the pop/push cases below stay simple.
  assign o_s_tready = !tail_vld_q;
  assign push       = i_s_tvalid && !tail_vld_q;
  assign pop        = head_vld_q && i_m_tready;

  assign o_m_tvalid = head_vld_q;
  assign o_m_tdata  = head_data_q;
  assign o_m_tlast  = head_vld_q && head_last_q;
  assign o_empty    = !head_vld_q;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge i_aclk) begin
    if (!i_aresetn) begin
      head_vld_q <= 1'b0;
      tail_vld_q <= 1'b0;
    end else if (pop) begin
      head_vld_q <= tail_vld_q || push;
      tail_vld_q <= 1'b0;
    end else if (push) begin
      if (head_vld_q) tail_vld_q <= 1'b1;
      else            head_vld_q <= 1'b1;
    end
  end

  // NOTE: payload registers are deliberately not reset; the valid flags
  // qualify them, and leaving them out of reset keeps the datapath cheap.
  always_ff @(posedge i_aclk) begin
    if (pop) begin
      if (tail_vld_q) begin
        head_data_q <= tail_data_q;
        head_last_q <= tail_last_q;
      end else if (push) begin
        head_data_q <= i_s_tdata;
        head_last_q <= i_s_tlast;
      end
    end else if (push) begin
      if (head_vld_q) begin
        tail_data_q <= i_s_tdata;
        tail_last_q <= i_s_tlast;
      end else begin
        head_data_q <= i_s_tdata;
        head_last_q <= i_s_tlast;
      end
    end
  end

endmodule

// File: rtl/fft_frame_tx.sv
// -----------------------------------------------------------------------------
// fft_frame_tx
// Cuts a raw complex sample stream into FFT_POINTS-long frames for an FFT
// wrapper: sends a one-cycle direction word on the config channel when
// framing starts, forwards samples with tlast on the final sample of each
// frame, and zero-pads a frame to completion on a flush request.
//
// Ports:
//   i_aclk, i_aresetn                  clock, synchronous active-low reset
//   i_enable                           start / continue framing (level)
//   i_cfg_fwd                          FFT direction (1 = forward)
//   i_flush                            pulse: zero-pad the current frame
//   i_axi4s_smp_*/o_axi4s_smp_tready   raw sample input {imag, real}
//   o_axi4s_cfg_tvalid/_tdata          config word, no ready
//   o_axi4s_data_*/i_axi4s_data_tready framed output stream
//   o_frame_cnt                        completed frames (wrapping)
//   o_busy                             not idle
// DATAIN_WIDTH must not exceed 32 (padding constant width).
// -----------------------------------------------------------------------------
module fft_frame_tx
  import fft_pkg::*;
#(
  parameter int DATAIN_WIDTH = 16,
  parameter int FFT_POINTS   = FFT_POINTS_DEFAULT
) (
  input  logic                      i_aclk,
  input  logic                      i_aresetn,
  input  logic                      i_enable,
  input  logic                      i_cfg_fwd,
  input  logic                      i_flush,
  input  logic                      i_axi4s_smp_tvalid,
  input  logic [2*DATAIN_WIDTH-1:0] i_axi4s_smp_tdata,
  output logic                      o_axi4s_smp_tready,
  output logic                      o_axi4s_cfg_tvalid,
  output logic                      o_axi4s_cfg_tdata,
  output logic                      o_axi4s_data_tvalid,
  output logic [2*DATAIN_WIDTH-1:0] o_axi4s_data_tdata,
  output logic                      o_axi4s_data_tlast,
  input  logic                      i_axi4s_data_tready,
  output logic [15:0]               o_frame_cnt,
  output logic                      o_busy
);

  localparam int               SAMPLE_W = 2 * DATAIN_WIDTH;
  localparam int               CNT_W    = cnt_width(FFT_POINTS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FFT_POINTS - 1);

  fsm_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [15:0]        frame_cnt_q;
  logic               cfg_vld_q, cfg_fwd_q, busy_q;

  logic               buf_ready, buf_empty;
  logic               out_vld, out_last;
  logic [SAMPLE_W-1:0] out_data;
  logic               cnt_zero, smp_ready, smp_push, pad_push, push;
  logic [SAMPLE_W-1:0] push_data;
  logic               push_last, tlast_done;

  // The counter tracks samples written into the skid buffer, so the tlast
  // tag travels with its sample. With the buffer empty it equals the number
  // of beats already delivered in the current frame.
  assign cnt_zero = (cnt_q == '0);

  // Once enable drops, only the remainder of the current frame is taken;
  // a flush pulse blocks acceptance in its own cycle.
  assign smp_ready = i_aresetn && (state_q == ST_STREAM) && buf_ready &&
                     !i_flush && (i_enable || !cnt_zero);
  assign smp_push  = i_axi4s_smp_tvalid && smp_ready;

  // Padding only continues while a frame is open; a flush that found the
  // last real sample already tagged needs no zeros.
  assign pad_push  = (state_q == ST_PAD) && buf_ready && !cnt_zero;
  assign push      = smp_push || pad_push;
  assign push_data = pad_push ? ZERO_SAMPLE[SAMPLE_W-1:0] : i_axi4s_smp_tdata;
  assign push_last = (cnt_q == CNT_LAST);

  assign tlast_done = out_vld && i_axi4s_data_tready && out_last;

  axi4s_skid_buf #(
    .DATA_W (SAMPLE_W)
  ) u_skid (
    .i_aclk     (i_aclk),
    .i_aresetn  (i_aresetn),
    .i_s_tvalid (push),
    .o_s_tready (buf_ready),
    .i_s_tdata  (push_data),
    .i_s_tlast  (push_last),
    .o_m_tvalid (out_vld),
    .i_m_tready (i_axi4s_data_tready),
    .o_m_tdata  (out_data),
    .o_m_tlast  (out_last),
    .o_empty    (buf_empty)
  );

  always_ff @(posedge i_aclk) begin
    if (!i_aresetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      frame_cnt_q <= '0;
      cfg_vld_q   <= 1'b0;
      cfg_fwd_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cfg_vld_q <= 1'b0;
      if (push)       cnt_q       <= cnt_q + CNT_W'(1);
      if (tlast_done) frame_cnt_q <= frame_cnt_q + 16'd1;

      case (state_q)
        ST_IDLE: begin
          if (i_enable) begin
            state_q   <= ST_CFG;
            cfg_vld_q <= 1'b1;
            cfg_fwd_q <= i_cfg_fwd;
            busy_q    <= 1'b1;
          end
        end
        ST_CFG: state_q <= ST_STREAM;
        ST_STREAM: begin
          // Flush wins over a simultaneous enable drop.
          if (i_flush && (!cnt_zero || !buf_empty)) begin
            state_q <= ST_PAD;
          end else if (!i_enable && cnt_zero && buf_empty) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_PAD: begin
          // With cnt_q at zero the tagged tlast is the newest buffered beat,
          // so this completion closes the padded frame.
          if (tlast_done && cnt_zero) begin
            state_q <= i_enable ? ST_STREAM : ST_IDLE;
            busy_q  <= i_enable;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_axi4s_smp_tready  = smp_ready;
  assign o_axi4s_cfg_tvalid  = cfg_vld_q;
  assign o_axi4s_cfg_tdata   = cfg_fwd_q;
  assign o_axi4s_data_tvalid = out_vld;
  assign o_axi4s_data_tdata  = out_data;
  assign o_axi4s_data_tlast  = out_last;
  assign o_frame_cnt         = frame_cnt_q;
  assign o_busy              = busy_q;

endmodule

// File: tb/tb_fft_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_fft_frame_tx
// Scoreboard bench for fft_frame_tx with 8-point frames. Directed scenarios
// push hand-derived expected beats into a queue; an independent monitor pops
// and compares every completed output beat and checks stall stability.
// -----------------------------------------------------------------------------
module tb_fft_frame_tx;

  localparam int DW   = 16;
  localparam int NPTS = 8;
  localparam int SW   = 2 * DW;

  typedef struct packed {
    logic [SW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          cfg_fwd = 1'b0;
  logic          flush = 1'b0;
  logic          smp_tvalid = 1'b0;
  logic [SW-1:0] smp_tdata = '0;
  logic          data_tready = 1'b0;
  logic          smp_tready, cfg_tvalid, cfg_tdata;
  logic          data_tvalid, data_tlast, busy;
  logic [SW-1:0] data_tdata;
  logic [15:0]   frame_cnt;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t exp_q[$];
  int    beats_seen = 0;
  int    cfg_pulses = 0;
  logic  last_cfg_data = 1'b0;
  int    cyc = 0;
  int    last_beat_cyc = 0;
  int    cfg_cyc = 0;
  int    src_idx = 0;
  int    src_limit = 32'h4000_0000;
  bit    src_on = 1'b0;
  bit    rand_ready = 1'b0;

  fft_frame_tx #(
    .DATAIN_WIDTH (DW),
    .FFT_POINTS   (NPTS)
  ) dut (
    .i_aclk              (clk),
    .i_aresetn           (rst_n),
    .i_enable            (enable),
    .i_cfg_fwd           (cfg_fwd),
    .i_flush             (flush),
    .i_axi4s_smp_tvalid  (smp_tvalid),
    .i_axi4s_smp_tdata   (smp_tdata),
    .o_axi4s_smp_tready  (smp_tready),
    .o_axi4s_cfg_tvalid  (cfg_tvalid),
    .o_axi4s_cfg_tdata   (cfg_tdata),
    .o_axi4s_data_tvalid (data_tvalid),
    .o_axi4s_data_tdata  (data_tdata),
    .o_axi4s_data_tlast  (data_tlast),
    .i_axi4s_data_tready (data_tready),
    .o_frame_cnt         (frame_cnt),
    .o_busy              (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Source sample i: nonzero in both halves so padding is distinguishable.
  function automatic logic [SW-1:0] sample(input int i);
    logic [15:0] re, im;
    re = 16'(i + 256);
    im = 16'(i + 40960);
    return {im, re};
  endfunction

  task automatic push_exp(input logic [SW-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    exp_q.push_back(b);
  endtask

  // n real samples from index first, tlast every NPTS-th from frame start.
  task automatic push_real(input int first, input int n);
    for (int k = 0; k < n; k++) push_exp(sample(first + k), (k % NPTS) == NPTS - 1);
  endtask

  task automatic wait_beats(input int n, input string name);
    int k = 0;
    while (beats_seen < n && k < 400) begin
      @(negedge clk); #1;
      k++;
    end
    check({name, "_beats"}, beats_seen >= n, 1);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((busy || exp_q.size() != 0) && k < 400) begin
      @(negedge clk); #1;
      k++;
    end
    check({name, "_idle"}, busy, 0);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Sample source: presents sample(src_idx); advances after each handshake.
  initial begin
    bit acc;
    forever begin
      @(negedge clk);
      acc = smp_tvalid && smp_tready;
      @(posedge clk); #1;
      if (acc) src_idx++;
      smp_tvalid = src_on && (src_idx < src_limit);
      smp_tdata  = sample(src_idx);
    end
  end

  // Random downstream backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) data_tready = ($urandom_range(0, 1) == 1);
    end
  end

  // Monitor: scoreboard pop on each completed beat, stall stability, cfg.
  initial begin
    bit          stalled = 1'b0;
    logic [SW:0] held = '0;
    beat_t       e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("stall_valid_hold", data_tvalid, 1);
          check("stall_payload_hold", {data_tdata, data_tlast}, held);
        end
        if (data_tvalid && data_tready) begin
          beats_seen++;
          last_beat_cyc = cyc;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: actual data 0x%0h last %0d required no beat",
                     data_tdata, data_tlast);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", data_tdata, e.data);
            check("beat_last", data_tlast, e.last);
          end
        end
        stalled = data_tvalid && !data_tready;
        held    = {data_tdata, data_tlast};
      end
      if (cfg_tvalid) begin
        cfg_pulses++;
        cfg_cyc       = cyc;
        last_cfg_data = cfg_tdata;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b0, c0, i0, e0;
    logic [15:0] f0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_data_tvalid", data_tvalid, 0);
    check("rst_data_tlast", data_tlast, 0);
    check("rst_smp_tready", smp_tready, 0);
    check("rst_cfg_tvalid", cfg_tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("idle_smp_tready", smp_tready, 0);

    // Two continuous frames, tready held high, forward config
    @(negedge clk); #1;
    b0 = beats_seen; c0 = cfg_pulses; i0 = src_idx;
    push_real(i0, 16);
    tick();
    cfg_fwd = 1'b1; data_tready = 1'b1; src_on = 1'b1; enable = 1'b1;
    e0 = cyc;
    wait_beats(b0 + 1, "t1_first");
    check("t1_first_beat_latency", last_beat_cyc, e0 + 4);
    check("t1_cfg_cycle", cfg_cyc, e0 + 2);
    wait_beats(b0 + 12, "t1_mid");
    tick();
    enable = 1'b0;
    wait_beats(b0 + 16, "t1_all");
    check("t1_throughput", last_beat_cyc, e0 + 19);
    wait_idle("t1");
    check("t1_frame_cnt", frame_cnt, 2);
    check("t1_cfg_pulses", cfg_pulses, c0 + 1);
    check("t1_cfg_data", last_cfg_data, 1);

    // Three frames under random backpressure, reverse config
    @(negedge clk); #1;
    rand_ready = 1'b1;
    b0 = beats_seen; c0 = cfg_pulses; i0 = src_idx; f0 = frame_cnt;
    push_real(i0, 24);
    tick();
    cfg_fwd = 1'b0; enable = 1'b1;
    wait_beats(b0 + 17, "t2_mid");
    tick();
    enable = 1'b0;
    wait_idle("t2");
    check("t2_beats", beats_seen, b0 + 24);
    check("t2_frame_cnt", frame_cnt, f0 + 16'd3);
    check("t2_cfg_pulses", cfg_pulses, c0 + 1);
    check("t2_cfg_data", last_cfg_data, 0);
    @(negedge clk);
    rand_ready = 1'b0;
    tick();
    data_tready = 1'b1;

    // Flush at a frame boundary with an empty buffer does nothing, then a
    // flush after 3 real samples pads 5 zeros (enable dropped together)
    @(negedge clk); #1;
    b0 = beats_seen; i0 = src_idx; f0 = frame_cnt;
    src_limit = i0;
    tick();
    enable = 1'b1;
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (4) tick();
    check("t3_boundary_flush_beats", beats_seen, b0);
    check("t3_boundary_flush_busy", busy, 1);
    push_real(i0, 3);
    for (int k = 3; k < NPTS; k++) push_exp('0, k == NPTS - 1);
    src_limit = i0 + 3;
    wait_beats(b0 + 3, "t3_real");
    tick();
    flush = 1'b1; enable = 1'b0;
    tick();
    flush = 1'b0;
    wait_idle("t3");
    check("t3_beats", beats_seen, b0 + 8);
    check("t3_frame_cnt", frame_cnt, f0 + 16'd1);
    check("t3_src_taken", src_idx, i0 + 3);
    src_limit = 32'h4000_0000;

    // Enable dropped after beat 5: frame completes, then stays idle
    @(negedge clk); #1;
    b0 = beats_seen; c0 = cfg_pulses; i0 = src_idx; f0 = frame_cnt;
    push_real(i0, 8);
    tick();
    cfg_fwd = 1'b1; enable = 1'b1;
    wait_beats(b0 + 5, "t4_mid");
    tick();
    enable = 1'b0;
    wait_idle("t4");
    repeat (10) tick();
    check("t4_beats", beats_seen, b0 + 8);
    check("t4_frame_cnt", frame_cnt, f0 + 16'd1);
    check("t4_cfg_pulses", cfg_pulses, c0 + 1);
    check("t4_busy", busy, 0);
    check("t4_data_tvalid", data_tvalid, 0);
    check("t4_src_taken", src_idx, i0 + 8);

    // Reset at beat 4 discards the partial frame; fresh frame afterwards
    @(negedge clk); #1;
    b0 = beats_seen; i0 = src_idx;
    push_real(i0, 4);
    tick();
    enable = 1'b1;
    wait_beats(b0 + 4, "t5_pre");
    tick();
    rst_n = 1'b0; enable = 1'b0; data_tready = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    check("t5_rst_data_tvalid", data_tvalid, 0);
    check("t5_rst_data_tlast", data_tlast, 0);
    check("t5_rst_smp_tready", smp_tready, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_cfg_tvalid", cfg_tvalid, 0);
    check("t5_rst_frame_cnt", frame_cnt, 0);
    check("t5_pre_reset_beats", beats_seen, b0 + 4);
    check("t5_pre_reset_drained", exp_q.size(), 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk); #1;
    b0 = beats_seen; c0 = cfg_pulses; i0 = src_idx;
    push_real(i0, 8);
    tick();
    cfg_fwd = 1'b1; data_tready = 1'b1; enable = 1'b1;
    wait_beats(b0 + 3, "t5_mid");
    tick();
    enable = 1'b0;
    wait_idle("t5");
    check("t5_frame_cnt", frame_cnt, 1);
    check("t5_cfg_pulses", cfg_pulses, c0 + 1);
    check("t5_cfg_data", last_cfg_data, 1);

    // Frame counter wrap from a preloaded value
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.frame_cnt_q;
    #1;
    check("t6_preload", frame_cnt, 16'hFFFE);
    b0 = beats_seen; i0 = src_idx;
    push_real(i0, 16);
    tick();
    enable = 1'b1;
    wait_beats(b0 + 8, "t6_f1");
    tick();
    check("t6_frame_cnt_ffff", frame_cnt, 16'hFFFF);
    wait_beats(b0 + 12, "t6_mid");
    tick();
    enable = 1'b0;
    wait_idle("t6");
    check("t6_frame_cnt_wrap", frame_cnt, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
